// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses a combinational instruction
// ROM, buffers {pc, instr} pairs in a small FIFO and hands them to decode.
// A redirect flushes every buffered word and restarts fetching at the target.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Handshake: a word transfers to decode on any rising edge where
  // out_valid && out_ready. out_valid is a pure function of registered
  // occupancy, and while out_ready is low the head word and its PC hold.

  logic [31:0]   pc;
  logic [31:0]   mem_pc    [FIFO_DEPTH];
  logic [31:0]   mem_instr [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;
  logic          unused_bits;

  // Targets are always word aligned; the low redirect bits are dropped.
  assign unused_bits = ^redirect_pc[1:0];

  assign instr_addr = pc;
  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push       = fetch_en & ~redirect_valid & ((count < DEPTH_C) | pop);

  // Head presentation, forced to zero when nothing is buffered.
  always_comb begin
    out_instr = 32'h0;
    out_pc    = 32'h0;
    if (out_valid) begin
      out_instr = mem_instr[rd_ptr];
      out_pc    = mem_pc[rd_ptr];
    end
  end

  // PC, pointers and occupancy; reset beats redirect, redirect beats fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only observed while counted as occupied.
  always_ff @(posedge clk) begin
    if (!reset && !redirect_valid && push) begin
      mem_pc[wr_ptr]    <= instr_addr;
      mem_instr[wr_ptr] <= instr_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a per-cycle vector table covering reset,
// streaming, back-pressure, redirect, PC wrap, fetch disable and
// reset-over-redirect, followed by a throughput run with irregular ready.
module tb_inst_fetch_unit;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .instr_addr     (instr_addr),
    .instr_data     (instr_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: two fixed words at 0 and 4, address-derived elsewhere.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0)      return 32'h0011_0233;
    else if (a == 32'h4) return 32'h4011_02B3;
    else                 return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  assign instr_data = rom(instr_addr);

  typedef struct {
    logic        rst;
    logic        fe;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ov;
    logic [31:0] pc;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] exp_q[$];

  task automatic add(input logic rst, input logic fe, input logic rv,
                     input logic [31:0] rpc, input logic rdy,
                     input logic ov, input logic [31:0] pc, input logic [31:0] addr);
    vec_t v;
    v.rst = rst; v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ov = ov; v.pc = pc; v.addr = addr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic fe, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
    reset = rst; fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // Columns: rst fe rv rpc rdy | exp out_valid out_pc instr_addr (after edge)
    // Streaming from reset
    add(1, 1, 0, 32'h0,          1, 0, 32'h0,          32'h0);
    add(0, 1, 0, 32'h0,          1, 1, 32'h0,          32'h4);
    add(0, 1, 0, 32'h0,          1, 1, 32'h4,          32'h8);
    add(0, 1, 0, 32'h0,          1, 1, 32'h8,          32'hC);
    // Back-pressure: fill to two entries, pc parks at 8, head stays at 0
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0);
    add(0, 1, 0, 32'h0,          0, 1, 32'h0,          32'h4);
    add(0, 1, 0, 32'h0,          0, 1, 32'h0,          32'h8);
    add(0, 1, 0, 32'h0,          0, 1, 32'h0,          32'h8);
    add(0, 1, 0, 32'h0,          0, 1, 32'h0,          32'h8);
    add(0, 1, 0, 32'h0,          0, 1, 32'h0,          32'h8);
    add(0, 1, 0, 32'h0,          1, 1, 32'h4,          32'hC);
    add(0, 1, 0, 32'h0,          1, 1, 32'h8,          32'h10);
    add(0, 1, 0, 32'h0,          1, 1, 32'hC,          32'h14);
    // Redirect while full at pc=8, misaligned target 0x26
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0);
    add(0, 1, 0, 32'h0,          0, 1, 32'h0,          32'h4);
    add(0, 1, 0, 32'h0,          0, 1, 32'h0,          32'h8);
    add(0, 1, 1, 32'h0000_0026,  0, 0, 32'h0,          32'h24);
    add(0, 1, 0, 32'h0,          0, 1, 32'h24,         32'h28);
    add(0, 1, 0, 32'h0,          1, 1, 32'h28,         32'h2C);
    // Redirect to the top word (with a simultaneous pop) and wrap to 0
    add(0, 1, 1, 32'hFFFF_FFFC,  1, 0, 32'h0,          32'hFFFF_FFFC);
    add(0, 1, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  32'h0);
    add(0, 1, 0, 32'h0,          1, 1, 32'h0,          32'h4);
    add(0, 1, 0, 32'h0,          1, 1, 32'h4,          32'h8);
    // fetch_en low drains two buffered entries, pc frozen
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,          32'h0);
    add(0, 1, 0, 32'h0,          0, 1, 32'h0,          32'h4);
    add(0, 1, 0, 32'h0,          0, 1, 32'h0,          32'h8);
    add(0, 0, 0, 32'h0,          1, 1, 32'h4,          32'h8);
    add(0, 0, 0, 32'h0,          1, 0, 32'h0,          32'h8);
    add(0, 0, 0, 32'h0,          1, 0, 32'h0,          32'h8);
    add(0, 1, 0, 32'h0,          1, 1, 32'h8,          32'hC);
    // Reset together with redirect while holding entries
    add(0, 1, 0, 32'h0,          0, 1, 32'h8,          32'h10);
    add(1, 1, 1, 32'h0000_0100,  0, 0, 32'h0,          32'h0);
    add(0, 1, 0, 32'h0,          1, 1, 32'h0,          32'h4);
    add(0, 1, 0, 32'h0,          1, 1, 32'h4,          32'h8);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fe, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ov});
      check($sformatf("v%0d out_pc", i), out_pc, vecs[i].pc);
      check($sformatf("v%0d out_instr", i), out_instr, vecs[i].ov ? rom(vecs[i].pc) : 32'h0);
      check($sformatf("v%0d instr_addr", i), instr_addr, vecs[i].addr);
    end

    // Irregular ready: every accepted word must be the next sequential PC,
    // with no gaps or duplicates, and the run must deliver at least 25 words.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 64; k++) exp_q.push_back(32'(k * 4));
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      out_ready = ((c % 3) != 1);
      @(negedge clk);
      if (out_valid && out_ready) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("stream out_pc", out_pc, e);
        check("stream out_instr", out_instr, rom(e));
      end
      @(posedge clk);
      #1;
    end
    check("stream words delivered", 32'(64 - exp_q.size()) >= 32'd25 ? 32'd1 : 32'd0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
